uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 143 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
// Host bytes are queued in a circular FIFO and sent LSB-first on tx. The
// frame FSM only moves on cycles where baud_tick is high, so each line
// level lasts exactly one tick-to-tick interval.
//
// Handshake (write side): wr_ready is !full, computed from registered pointers
// only. A byte transfers on any rising clk edge where wr_valid && wr_ready.
// wr_data is sampled only on that edge. wr_valid may be raised or dropped
// freely; the host needs no other flow control.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,           // power of 2, at least 2
  localparam int ADDR_W = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,           // asynchronous, active-low
  input  logic              baud_tick,
  input  logic [7:0]        wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              tx,
  output logic              tx_busy,
  output logic [ADDR_W:0]   fifo_count,
  output logic [1:0]        state_dbg      // current FSM state, for observation
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [2:0]      LAST_BIT = 3'd7;

  state_t            state;
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [7:0]        head;
  logic [7:0]        shreg;
  logic [2:0]        bit_idx;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              load_slot;

  // Pointers carry one extra wrap bit: equal means empty, equal except for
  // the wrap bit means full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // A push is decided on registered full only; a pop on the same edge
  // does not make room for it.
  assign push = wr_valid && !full;

  // The FSM can take a new byte only at a tick in IDLE or at the end of STOP.
  assign load_slot = (state == IDLE) || (state == STOP);
  assign pop       = baud_tick && load_slot && !empty;

  assign head       = mem[rd_ptr[ADDR_W-1:0]];
  assign wr_ready   = !full;
  assign fifo_count = wr_ptr - rd_ptr;
  assign state_dbg  = state;

  // FIFO pointer update; push and pop on one edge leave the count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // FIFO storage write; contents need no reset because pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  // Frame FSM with registered tx/tx_busy; it advances only on baud ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      shreg   <= '0;
      bit_idx <= '0;
    end else if (baud_tick) begin
      case (state)
        IDLE: begin
          if (!empty) begin
            shreg   <= head;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          tx      <= shreg[0];
          bit_idx <= '0;
          state   <= DATA;
        end
        DATA: begin
          if (bit_idx == LAST_BIT) begin
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            tx      <= shreg[bit_idx + 3'd1];
            bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          // Back-to-back path: the next start bit follows the stop bit
          // directly when another byte is already queued.
          if (!empty) begin
            shreg <= head;
            tx    <= 1'b0;
            state <= START;
          end else begin
            tx_busy <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based line model predicts tx, tx_busy,
// fifo_count and wr_ready every cycle; scenario tasks add directed checks.
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             baud_tick = 1'b0;
  logic [7:0]       wr_data = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic             tx;
  logic             tx_busy;
  logic [CNT_W-1:0] fifo_count;
  logic [1:0]       state_dbg;

  int tests_run = 0;
  int failed    = 0;
  int tick_div  = 0;
  int tick_cnt  = 0;

  // Reference model: queued bytes plus the line levels still to be sent.
  logic [7:0]       exp_q[$];
  bit               line_q[$];
  logic             m_tx   = 1'b1;
  logic             m_busy = 1'b0;
  logic [CNT_W-1:0] m_cnt  = '0;
  logic             m_rdy  = 1'b1;
  int               pre_sz;
  logic [7:0]       pop_b;

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .tx         (tx),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count),
    .state_dbg  (state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Model: on a tick, send the next pending level; with none pending, start
  // a new frame if a byte was already queued before this edge, else idle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q.delete();
      line_q.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end else begin
      pre_sz = exp_q.size();
      if (baud_tick) begin
        if (line_q.size() != 0) begin
          m_tx = line_q.pop_front();
        end else if (pre_sz != 0) begin
          pop_b = exp_q.pop_front();
          m_tx   = 1'b0;
          m_busy = 1'b1;
          for (int i = 0; i < 8; i++) line_q.push_back(pop_b[i]);
          line_q.push_back(1'b1);
        end else begin
          m_tx   = 1'b1;
          m_busy = 1'b0;
        end
      end
      if (wr_valid && (pre_sz < DEPTH)) exp_q.push_back(wr_data);
    end
    m_cnt = CNT_W'(exp_q.size());
    m_rdy = (exp_q.size() < DEPTH);
  end

  // Driver: advance one clock, then set baud_tick for the next edge.
  task automatic clk_step();
    @(posedge clk);
    #1;
    if (tick_div == 0) begin
      baud_tick = 1'b0;
    end else begin
      tick_cnt++;
      if (tick_cnt >= tick_div) begin
        tick_cnt  = 0;
        baud_tick = 1'b1;
      end else begin
        baud_tick = 1'b0;
      end
    end
  endtask

  task automatic set_ticks(input int div);
    tick_div = div;
    tick_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_ticks(0);
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({tx, tx_busy, fifo_count, wr_ready, state_dbg} !== {1'b1, 1'b0, CNT_W'(0), 1'b1, 2'd0}) begin
      failed++;
      $display("FAIL reset_values: tx/busy/cnt/rdy/state=%b/%b/%0d/%b/%0d expected 1/0/0/1/0",
               tx, tx_busy, fifo_count, wr_ready, state_dbg);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clk_step();
      tests_run++;
      if ({tx, tx_busy, fifo_count, wr_ready} !== {m_tx, m_busy, m_cnt, m_rdy}) begin
        failed++;
        $display("FAIL reset_idle t=%0t tx/busy/cnt/rdy=%b/%b/%0d/%b expected %b/%b/%0d/%b",
                 $time, tx, tx_busy, fifo_count, wr_ready, m_tx, m_busy, m_cnt, m_rdy);
      end
    end
  endtask

  task automatic test_single_byte();
    int   busy_n;
    int   bad;
    int   max_cnt;
    logic samp_q[$];
    bit   exp_bits[10];
    exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    busy_n  = 0;
    bad     = 0;
    max_cnt = 0;
    set_ticks(4);
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    for (int i = 0; i < 60; i++) begin
      clk_step();
      wr_valid = 1'b0;
      tests_run++;
      if ({tx, tx_busy, fifo_count, wr_ready} !== {m_tx, m_busy, m_cnt, m_rdy}) begin
        failed++;
        $display("FAIL single_byte t=%0t tx/busy/cnt/rdy=%b/%b/%0d/%b expected %b/%b/%0d/%b",
                 $time, tx, tx_busy, fifo_count, wr_ready, m_tx, m_busy, m_cnt, m_rdy);
      end
      if (tx_busy === 1'b1) begin
        busy_n++;
        samp_q.push_back(tx);
      end
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end
    tests_run++;
    if (busy_n != 40) begin
      failed++;
      $display("FAIL single_busy_len: busy for %0d clk, expected 40", busy_n);
    end
    for (int i = 0; i < 40; i++) begin
      if (i >= samp_q.size()) bad++;
      else if (samp_q[i] !== exp_bits[i / 4]) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      failed++;
      $display("FAIL single_waveform: %0d of 40 line samples differ from 0,1,0,1,0,0,1,0,1,1 x4", bad);
    end
    tests_run++;
    if (max_cnt != 1) begin
      failed++;
      $display("FAIL single_count_peak: fifo_count peaked at %0d, expected 1", max_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[3];
    int   busy_n;
    int   rises;
    logic prev_busy;
    bytes = '{8'h00, 8'hFF, 8'h3C};
    busy_n = 0;
    rises  = 0;
    prev_busy = tx_busy;
    set_ticks(4);
    for (int i = 0; i < 143; i++) begin
      if (i < 3) begin
        wr_valid = 1'b1;
        wr_data  = bytes[i];
      end else begin
        wr_valid = 1'b0;
      end
      clk_step();
      tests_run++;
      if ({tx, tx_busy, fifo_count, wr_ready} !== {m_tx, m_busy, m_cnt, m_rdy}) begin
        failed++;
        $display("FAIL back_to_back t=%0t tx/busy/cnt/rdy=%b/%b/%0d/%b expected %b/%b/%0d/%b",
                 $time, tx, tx_busy, fifo_count, wr_ready, m_tx, m_busy, m_cnt, m_rdy);
      end
      if (tx_busy === 1'b1) busy_n++;
      if (tx_busy === 1'b1 && prev_busy !== 1'b1) rises++;
      prev_busy = tx_busy;
    end
    wr_valid = 1'b0;
    tests_run++;
    if (busy_n != 120 || rises != 1) begin
      failed++;
      $display("FAIL b2b_busy: busy %0d clk in %0d bursts, expected 120 clk in 1 burst", busy_n, rises);
    end
  endtask

  task automatic test_full_fifo();
    logic [7:0] bytes[5];
    int   idx;
    logic acc;
    for (int i = 0; i < 5; i++) bytes[i] = 8'($urandom);
    idx = 0;
    set_ticks(0);
    wr_valid = 1'b1;
    wr_data  = bytes[0];
    for (int i = 0; i < 280; i++) begin
      if (i == 20) begin
        tests_run++;
        if ({fifo_count, wr_ready} !== {CNT_W'(4), 1'b0} || idx != 4) begin
          failed++;
          $display("FAIL full_hold: cnt/rdy/accepted=%0d/%b/%0d expected 4/0/4", fifo_count, wr_ready, idx);
        end
        set_ticks(4);
      end
      acc = wr_valid && wr_ready;
      clk_step();
      if (acc) begin
        idx++;
        if (idx < 5) wr_data = bytes[idx];
        else wr_valid = 1'b0;
      end
      tests_run++;
      if ({tx, tx_busy, fifo_count, wr_ready} !== {m_tx, m_busy, m_cnt, m_rdy}) begin
        failed++;
        $display("FAIL full_fifo t=%0t tx/busy/cnt/rdy=%b/%b/%0d/%b expected %b/%b/%0d/%b",
                 $time, tx, tx_busy, fifo_count, wr_ready, m_tx, m_busy, m_cnt, m_rdy);
      end
    end
    wr_valid = 1'b0;
    tests_run++;
    if (idx != 5) begin
      failed++;
      $display("FAIL full_fifth_accept: %0d bytes accepted, expected 5", idx);
    end
  endtask

  task automatic test_push_on_tick();
    int found;
    found = 0;
    set_ticks(4);
    for (int i = 0; i < 12 && found == 0; i++) begin
      clk_step();
      if (baud_tick) found = 1;
    end
    tests_run++;
    if (found == 0 || m_busy !== 1'b0) begin
      failed++;
      $display("FAIL tick_push_setup: found=%0d idle=%b, expected idle tick cycle", found, !m_busy);
    end
    wr_valid = 1'b1;
    wr_data  = 8'h81;
    for (int i = 0; i < 5; i++) begin
      clk_step();
      wr_valid = 1'b0;
      tests_run++;
      if (tx !== ((i < 4) ? 1'b1 : 1'b0)) begin
        failed++;
        $display("FAIL tick_push_delay: clk %0d after push tx=%b expected %b", i, tx, (i < 4) ? 1'b1 : 1'b0);
      end
    end
    for (int i = 0; i < 45; i++) begin
      clk_step();
      tests_run++;
      if ({tx, tx_busy, fifo_count, wr_ready} !== {m_tx, m_busy, m_cnt, m_rdy}) begin
        failed++;
        $display("FAIL tick_push_frame t=%0t tx/busy/cnt/rdy=%b/%b/%0d/%b expected %b/%b/%0d/%b",
                 $time, tx, tx_busy, fifo_count, wr_ready, m_tx, m_busy, m_cnt, m_rdy);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int found;
    int noisy;
    found = 0;
    noisy = 0;
    set_ticks(4);
    for (int i = 0; i < 80 && found == 0; i++) begin
      if (i < 3) begin
        wr_valid = 1'b1;
        wr_data  = (i == 0) ? 8'h55 : 8'($urandom);
      end else begin
        wr_valid = 1'b0;
      end
      clk_step();
      tests_run++;
      if ({tx, tx_busy, fifo_count, wr_ready} !== {m_tx, m_busy, m_cnt, m_rdy}) begin
        failed++;
        $display("FAIL rst_mid_run t=%0t tx/busy/cnt/rdy=%b/%b/%0d/%b expected %b/%b/%0d/%b",
                 $time, tx, tx_busy, fifo_count, wr_ready, m_tx, m_busy, m_cnt, m_rdy);
      end
      // d3 is on the line once five levels (d4..d7, stop) remain.
      if (i >= 3 && m_busy && line_q.size() == 5) found = 1;
    end
    wr_valid = 1'b0;
    clk_step();
    tests_run++;
    if (found == 0 || fifo_count !== CNT_W'(2) || tx !== 1'b0) begin
      failed++;
      $display("FAIL rst_mid_setup: found=%0d cnt=%0d tx=%b expected 1/2/0", found, fifo_count, tx);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if ({tx, tx_busy, fifo_count, wr_ready, state_dbg} !== {1'b1, 1'b0, CNT_W'(0), 1'b1, 2'd0}) begin
      failed++;
      $display("FAIL rst_mid_async: tx/busy/cnt/rdy/state=%b/%b/%0d/%b/%0d expected 1/0/0/1/0",
               tx, tx_busy, fifo_count, wr_ready, state_dbg);
    end
    repeat (3) clk_step();
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      clk_step();
      if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== CNT_W'(0)) noisy++;
      tests_run++;
      if ({tx, tx_busy, fifo_count, wr_ready} !== {m_tx, m_busy, m_cnt, m_rdy}) begin
        failed++;
        $display("FAIL rst_mid_after t=%0t tx/busy/cnt/rdy=%b/%b/%0d/%b expected %b/%b/%0d/%b",
                 $time, tx, tx_busy, fifo_count, wr_ready, m_tx, m_busy, m_cnt, m_rdy);
      end
    end
    tests_run++;
    if (noisy != 0) begin
      failed++;
      $display("FAIL rst_mid_quiet: %0d non-idle cycles after release, expected 0", noisy);
    end
  endtask

  task automatic test_simul_push_pop();
    int found;
    found = 0;
    set_ticks(4);
    for (int i = 0; i < 200 && found == 0; i++) begin
      if (i < 3) begin
        wr_valid = 1'b1;
        wr_data  = 8'($urandom);
      end else begin
        wr_valid = 1'b0;
      end
      clk_step();
      tests_run++;
      if ({tx, tx_busy, fifo_count, wr_ready} !== {m_tx, m_busy, m_cnt, m_rdy}) begin
        failed++;
        $display("FAIL pushpop_run t=%0t tx/busy/cnt/rdy=%b/%b/%0d/%b expected %b/%b/%0d/%b",
                 $time, tx, tx_busy, fifo_count, wr_ready, m_tx, m_busy, m_cnt, m_rdy);
      end
      if (i >= 3 && baud_tick && m_busy && line_q.size() == 0 && exp_q.size() == 2) found = 1;
    end
    tests_run++;
    if (found == 0 || fifo_count !== CNT_W'(2)) begin
      failed++;
      $display("FAIL pushpop_setup: found=%0d cnt=%0d expected 1/2", found, fifo_count);
    end
    wr_valid = 1'b1;
    wr_data  = 8'($urandom);
    clk_step();
    wr_valid = 1'b0;
    tests_run++;
    if (fifo_count !== CNT_W'(2) || tx !== 1'b0) begin
      failed++;
      $display("FAIL pushpop_count: cnt=%0d tx=%b expected 2/0", fifo_count, tx);
    end
    for (int i = 0; i < 130; i++) begin
      clk_step();
      tests_run++;
      if ({tx, tx_busy, fifo_count, wr_ready} !== {m_tx, m_busy, m_cnt, m_rdy}) begin
        failed++;
        $display("FAIL pushpop_drain t=%0t tx/busy/cnt/rdy=%b/%b/%0d/%b expected %b/%b/%0d/%b",
                 $time, tx, tx_busy, fifo_count, wr_ready, m_tx, m_busy, m_cnt, m_rdy);
      end
    end
  endtask

  task automatic test_continuous_tick();
    int busy_n;
    busy_n = 0;
    set_ticks(1);
    for (int i = 0; i < 40; i++) begin
      if (i < 2) begin
        wr_valid = 1'b1;
        wr_data  = 8'($urandom);
      end else begin
        wr_valid = 1'b0;
      end
      clk_step();
      tests_run++;
      if ({tx, tx_busy, fifo_count, wr_ready} !== {m_tx, m_busy, m_cnt, m_rdy}) begin
        failed++;
        $display("FAIL cont_tick t=%0t tx/busy/cnt/rdy=%b/%b/%0d/%b expected %b/%b/%0d/%b",
                 $time, tx, tx_busy, fifo_count, wr_ready, m_tx, m_busy, m_cnt, m_rdy);
      end
      if (tx_busy === 1'b1) busy_n++;
    end
    tests_run++;
    if (busy_n != 20) begin
      failed++;
      $display("FAIL cont_tick_len: busy %0d clk, expected 20", busy_n);
    end
  endtask

  task automatic test_random(input int rounds);
    for (int r = 0; r < rounds; r++) begin
      set_ticks($urandom_range(1, 6));
      for (int i = 0; i < 700; i++) begin
        wr_valid = (i < 350) && ($urandom_range(0, 3) == 0);
        wr_data  = 8'($urandom);
        clk_step();
        tests_run++;
        if ({tx, tx_busy, fifo_count, wr_ready} !== {m_tx, m_busy, m_cnt, m_rdy}) begin
          failed++;
          $display("FAIL random r%0d t=%0t tx/busy/cnt/rdy=%b/%b/%0d/%b expected %b/%b/%0d/%b",
                   r, $time, tx, tx_busy, fifo_count, wr_ready, m_tx, m_busy, m_cnt, m_rdy);
        end
      end
      wr_valid = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_fifo();
    test_push_on_tick();
    test_reset_mid_frame();
    test_simul_push_pop();
    test_continuous_tick();
    test_random(3);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
